// File: rtl/if_stage.sv
// Instruction-fetch stage of the P7 MIPS core: PC register, IF/ID register,
// AdEL detection. Optional counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] npc_in,
  input  logic        is_br_d,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] pc4_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        bd_d,
  output logic [4:0]  exc_d,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
);

  // 33-bit end bound so a fetch window reaching 2^32 still compares correctly.
  localparam logic [32:0] IM_END   = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_bd_q, ifid_bd_d;
  logic [4:0]  ifid_exc_q, ifid_exc_d;
  logic        fault_f;

  assign pc_f      = pc_f_q;
  assign pc4_f     = pc_f_q + 32'd4;
  assign imem_addr = pc_f_q;
  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign pc4_d     = ifid_pc4_q;
  assign bd_d      = ifid_bd_q;
  assign exc_d     = ifid_exc_q;

  assign fault_f = (pc_f_q[1:0] != 2'b00) || (pc_f_q < IM_BASE) ||
                   ({1'b0, pc_f_q} >= IM_END);

  always_comb begin
    pc_f_d       = pc_f_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_bd_d    = ifid_bd_q;
    ifid_exc_d   = ifid_exc_q;
    if (exc_req || eret_req) begin
      // Flush: the fetched instruction is discarded, stall is overridden.
      pc_f_d       = exc_req ? EXC_VEC : epc;
      ifid_instr_d = 32'd0;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc4_f;
      ifid_bd_d    = 1'b0;
      ifid_exc_d   = EXC_NONE;
    end else if (!stall) begin
      // A taken branch still loads its delay slot into IF/ID.
      pc_f_d       = br_taken ? npc_in : pc4_f;
      ifid_instr_d = fault_f ? 32'd0 : imem_rdata;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc4_f;
      ifid_bd_d    = is_br_d;
      ifid_exc_d   = fault_f ? EXC_ADEL : EXC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q       <= RESET_PC;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= RESET_PC;
      ifid_pc4_q   <= RESET_PC + 32'd4;
      ifid_bd_q    <= 1'b0;
      ifid_exc_q   <= EXC_NONE;
    end else begin
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_bd_q    <= ifid_bd_d;
      ifid_exc_q   <= ifid_exc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        fetch_evt, stall_evt;
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign fetch_evt = !(exc_req || eret_req) && !stall;
  assign stall_evt = !(exc_req || eret_req) && stall;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (fetch_evt) perf_fetch_d = perf_fetch_q + 32'd1;
    if (stall_evt) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_fetch = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Table-driven bench for if_stage: each vector's expected IF state is queued
// when driven and compared one edge later; hand sequences cover reset cases.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] npc_in;
  logic        is_br_d;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        bd_d;
  logic [4:0]  exc_d;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .npc_in(npc_in), .is_br_d(is_br_d), .exc_req(exc_req),
    .eret_req(eret_req), .epc(epc), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc_f(pc_f), .pc4_f(pc4_f),
    .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d), .bd_d(bd_d),
    .exc_d(exc_d), .perf_fetch(perf_fetch), .perf_stall(perf_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, br, isbr, exc, eret;
    logic [31:0] npc, epc, rdata;
    logic [31:0] e_pc, e_instr, e_pcd;
    logic        e_bd;
    logic [4:0]  e_exc;
  } vec_t;

  localparam int EW = 32 * 3 + 1 + 5;
  logic [EW-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;
  int exp_fetch = 0;
  int exp_stall = 0;
  vec_t vecs[$];

  localparam logic [31:0] IA = 32'h2401_0001;
  localparam logic [31:0] IB = 32'h8C22_0004;
  localparam logic [31:0] IC = 32'h1111_1111;
  localparam logic [31:0] ID = 32'h0000_0020;
  localparam logic [31:0] IE = 32'h3C1F_ABCD;
  localparam logic [31:0] IF = 32'hAC05_0008;

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] n,
                              input logic ib, input logic x, input logic r,
                              input logic [31:0] ep, input logic [31:0] rd,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pcd, input logic e_bd,
                              input logic [4:0] e_exc);
    vec_t v;
    v.stall = s; v.br = b; v.npc = n; v.isbr = ib; v.exc = x; v.eret = r;
    v.epc = ep; v.rdata = rd; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_pcd = e_pcd; v.e_bd = e_bd; v.e_exc = e_exc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_perf();
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch, 32'(exp_fetch));
    check("perf_stall", perf_stall, 32'(exp_stall));
`else
    check("perf_fetch", perf_fetch, 32'd0);
    check("perf_stall", perf_stall, 32'd0);
`endif
  endtask

  // driver
  task automatic idle_inputs();
    stall = 0; br_taken = 0; npc_in = 0; is_br_d = 0;
    exc_req = 0; eret_req = 0; epc = 0; imem_rdata = 0;
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; br_taken = v.br; npc_in = v.npc; is_br_d = v.isbr;
    exc_req = v.exc; eret_req = v.eret; epc = v.epc; imem_rdata = v.rdata;
    exp_q.push_back({v.e_pc, v.e_instr, v.e_pcd, v.e_bd, v.e_exc});
    if (!(v.exc || v.eret)) begin
      if (v.stall) exp_stall++;
      else exp_fetch++;
    end
  endtask

  // scoreboard
  task automatic compare_front(input int idx);
    logic [EW-1:0] e;
    logic [31:0] e_pc, e_instr, e_pcd;
    logic        e_bd;
    logic [4:0]  e_exc;
    string       tag;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty: got 0 entries want 1 (vec %0d)", idx);
      return;
    end
    e = exp_q.pop_front();
    {e_pc, e_instr, e_pcd, e_bd, e_exc} = e;
    tag = $sformatf("v%0d", idx);
    check({tag, ".pc_f"}, pc_f, e_pc);
    check({tag, ".pc4_f"}, pc4_f, e_pc + 32'd4);
    check({tag, ".imem_addr"}, imem_addr, e_pc);
    check({tag, ".instr_d"}, instr_d, e_instr);
    check({tag, ".pc_d"}, pc_d, e_pcd);
    check({tag, ".pc4_d"}, pc4_d, e_pcd + 32'd4);
    check({tag, ".bd_d"}, {31'd0, bd_d}, {31'd0, e_bd});
    check({tag, ".exc_d"}, {27'd0, exc_d}, {27'd0, e_exc});
    check_perf();
  endtask

  initial begin
    // stall br npc isbr exc eret epc rdata | pc_f instr pc_d bd exc
    vecs.push_back(mk(0,0,0,0,0,0,0,IA, 32'h3004, IA, 32'h3000, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,IA, 32'h3008, IA, 32'h3004, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,IA, 32'h300C, IA, 32'h3008, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,IB, 32'h3010, IB, 32'h300C, 0, 0));
    vecs.push_back(mk(1,0,0,0,0,0,0,IC, 32'h3010, IB, 32'h300C, 0, 0));
    vecs.push_back(mk(1,0,0,1,0,0,0,IC, 32'h3010, IB, 32'h300C, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,0,0,IC, 32'h3014, IC, 32'h3010, 1, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,ID, 32'h3018, ID, 32'h3014, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,ID, 32'h301C, ID, 32'h3018, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,ID, 32'h3020, ID, 32'h301C, 0, 0));
    vecs.push_back(mk(0,1,32'h3100,1,0,0,0,IE, 32'h3100, IE, 32'h3020, 1, 0));
    vecs.push_back(mk(1,1,32'h3200,0,0,0,0,IF, 32'h3100, IE, 32'h3020, 1, 0));
    vecs.push_back(mk(0,1,32'h3200,0,0,0,0,IF, 32'h3200, IF, 32'h3100, 0, 0));
    vecs.push_back(mk(1,0,0,0,1,1,32'h3300,IA, 32'h4180, 0, 32'h3200, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,IA, 32'h4184, IA, 32'h4180, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,1,32'h3002,IB, 32'h3002, 0, 32'h4184, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,IB, 32'h3006, 0, 32'h3002, 0, 4));
    vecs.push_back(mk(0,1,32'h6FFC,0,0,0,0,IC, 32'h6FFC, 0, 32'h3006, 0, 4));
    vecs.push_back(mk(0,0,0,0,0,0,0,IC, 32'h7000, IC, 32'h6FFC, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,ID, 32'h7004, 0, 32'h7000, 0, 4));
    vecs.push_back(mk(0,1,32'h2FFC,0,0,0,0,ID, 32'h2FFC, 0, 32'h7004, 0, 4));
    vecs.push_back(mk(0,0,0,0,0,0,0,IE, 32'h3000, 0, 32'h2FFC, 0, 4));
    vecs.push_back(mk(0,0,0,0,0,0,0,IE, 32'h3004, IE, 32'h3000, 0, 0));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0,0,IA, 32'hFFFF_FFFC, IA, 32'h3004, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0,IB, 32'h0000_0000, 0, 32'hFFFF_FFFC, 0, 4));

    // reset
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    exp_fetch = 0;
    exp_stall = 0;
    check("rst.pc_f", pc_f, 32'h3000);
    check("rst.pc4_f", pc4_f, 32'h3004);
    check("rst.imem_addr", imem_addr, 32'h3000);
    check("rst.instr_d", instr_d, 32'h0);
    check("rst.pc_d", pc_d, 32'h3000);
    check("rst.pc4_d", pc4_d, 32'h3004);
    check("rst.bd_d", {31'd0, bd_d}, 32'd0);
    check("rst.exc_d", {27'd0, exc_d}, 32'd0);
    check_perf();

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      compare_front(i);
    end

    // reset while stalled with a redirect pending
    stall = 1; br_taken = 1; npc_in = 32'h5000; imem_rdata = IA;
    @(posedge clk);
    #1;
    check("st.pc_hold", pc_f, 32'h0);
    exp_stall++;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    exp_fetch = 0;
    exp_stall = 0;
    check("rst2.pc_f", pc_f, 32'h3000);
    check("rst2.instr_d", instr_d, 32'h0);
    check("rst2.pc_d", pc_d, 32'h3000);
    check("rst2.pc4_d", pc4_d, 32'h3004);
    check("rst2.exc_d", {27'd0, exc_d}, 32'd0);
    check_perf();

    idle_inputs();
    imem_rdata = IA;
    drive(mk(0,0,0,0,0,0,0,IA, 32'h3004, IA, 32'h3000, 0, 0));
    @(posedge clk);
    #1;
    compare_front(99);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the P7 pipelined MIPS core.
- Owns the PC register and the IF/ID pipeline register.
- Drives the instruction-memory address and supplies pc4 to the next-PC unit, which computes the branch/jump target in ID.
- Applies the next-PC redirect, exception vectoring and ERET return, stall/flush rules, delay-slot marking, and fetch-address exception (AdEL) detection.

Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset.
- EXC_VEC, 32'h0000_4180: exception handler entry address.
- IM_BASE, 32'h0000_3000: lowest legal fetch address.
- IM_WORDS, 4096: instruction memory size in words. The legal range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard stall from ID; hold PC and IF/ID.
- br_taken  in  1  ID instruction redirects the PC (branch taken or j/jal/jr).
- npc_in  in  32  redirect target from the next-PC unit.
- is_br_d  in  1  the ID instruction is a branch/jump, whether or not taken.
- exc_req  in  1  CP0 exception/interrupt taken this cycle.
- eret_req  in  1  ERET committing this cycle.
- epc  in  32  CP0 EPC.
- imem_addr  out  32  fetch address, equal to pc_f.
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- pc_f  out  32  current PC.
- pc4_f  out  32  pc_f+4, feeds the next-PC unit.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc4_d  out  32  IF/ID PC+4.
- bd_d  out  1  IF/ID instruction is in a branch delay slot.
- exc_d  out  5  IF/ID exception code: 0 = none, 4 = AdEL.
- perf_fetch  out  32  fetched-instruction count (optional feature).
- perf_stall  out  32  stall-cycle count (optional feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: pc_f=RESET_PC; instr_d=0; pc_d=RESET_PC; pc4_d=RESET_PC+4; bd_d=0; exc_d=0; perf counters=0.
- Reset applies on the clock edge, overrides everything, and is safe mid-stall or mid-redirect.
- Combinational outputs: pc4_f = pc_f+4, modulo 2^32 wrap. imem_addr = pc_f.
- Fetch fault: fault_f = (pc_f[1:0]!=0) or pc_f<IM_BASE or pc_f>=IM_BASE+4*IM_WORDS.
- On fault the fetched word is replaced by 0 (nop) and the exception code is 4.
- Per-edge priority (highest first):
  1. exc_req: pc_f<=EXC_VEC; IF/ID flushed (instr_d=0, exc_d=0, bd_d=0, pc_d<=pc_f, pc4_d<=pc4_f). Ignores stall.
  2. eret_req: pc_f<=epc; IF/ID flushed as in 1. Ignores stall.
  3. stall: pc_f and all IF/ID outputs hold.
  4. br_taken: pc_f<=npc_in. IF/ID loads the current fetch normally; this is the delay slot, so it is not flushed.
  5. Otherwise: pc_f<=pc4_f and IF/ID loads the fetch.
- IF/ID load (cases 4 and 5):
  - instr_d <= fault_f ? 0 : imem_rdata
  - pc_d <= pc_f
  - pc4_d <= pc4_f
  - exc_d <= fault_f ? 4 : 0
  - bd_d <= is_br_d
- Latency: one cycle from PC to the IF/ID register; redirect takes effect on the next fetch.
- Simultaneous events:
  - exc_req with eret_req → exc_req wins.
  - stall with br_taken → stall wins; ID re-presents br_taken after the stall.
- A redirect to an illegal address (for example npc_in or epc unaligned) is not blocked: the fault is raised on that fetch via exc_d=4.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined:
  - perf_fetch increments on every IF/ID load (cases 4 and 5).
  - perf_stall increments on every cycle in case 3.
  - Both are 32-bit wrapping counters, cleared by reset, and not cleared by flush.
- When undefined: both outputs are constant 0 and no counter registers are synthesised.

Test Plan:
- Reset then 3 free-running cycles with imem returning 0x24010001 → pc_f goes 0x3000, 0x3004, 0x3008, 0x300C; pc_d=0x3008, instr_d=0x24010001, exc_d=0.
- Stall high 2 cycles at pc_f=0x3010 → pc_f and IF/ID unchanged for both cycles; perf_stall+=2 with IF_PERF_CNT_EN, perf_fetch unchanged.
- br_taken=1, npc_in=0x3100, is_br_d=1 at pc_f=0x3020 → next pc_f=0x3100; pc_d=0x3020, bd_d=1 (delay slot kept).
- exc_req=1 together with stall=1 and eret_req=1 → pc_f=0x4180; instr_d=0, bd_d=0, exc_d=0.
- eret_req=1, epc=0x3002 → pc_f=0x3002; next IF/ID load has instr_d=0, exc_d=4.
- Free run from pc_f=0x6FFC (last legal word) → next fetch 0x7000 yields exc_d=4, instr_d=0; reset asserted mid-stall → pc_f=0x3000 the following cycle.
